// File: rtl/event_store_pkg.sv
// Shared constants, S2MM status/error bit positions and FSM states for the
// event store write path.
package event_store_pkg;

  localparam logic [18:0] START_OFFSET_DEF = 19'h03E00;
  localparam logic [18:0] EVENT_BYTES_DEF  = 19'd459008;
  localparam int          TRACK_DEPTH_DEF  = 4;

  // S2MM status byte {OK, SLVERR, DECERR, INTERR, tag[3:0]}
  localparam int STS_OK     = 7;
  localparam int STS_SLVERR = 6;
  localparam int STS_DECERR = 5;
  localparam int STS_INTERR = 4;

  // Completion error byte
  localparam int ERR_NOT_OK   = 0;
  localparam int ERR_RESP     = 1;
  localparam int ERR_INTERR   = 2;
  localparam int ERR_SHORT    = 3;
  localparam int ERR_OVERFLOW = 4;
  localparam int ERR_TAG      = 5;

  typedef enum logic [1:0] {IDLE, ISSUE_CMD, STREAM, DRAIN} state_t;

  function automatic logic [15:0] qwords_of(input logic [18:0] bytes);
    return 16'(bytes >> 3);
  endfunction

  // 72-bit S2MM command: tag in [71:68], 32-bit address with the buffer upper
  // address above the payload offset, DRR=0, EOF=1, DSA=0, INCR=1, 23-bit BTT.
  function automatic logic [71:0] make_cmd(input logic [3:0]  tag,
                                           input logic [11:0] upper_addr,
                                           input logic [18:0] offset,
                                           input logic [18:0] btt);
    return {tag, 4'h0, 1'b0, upper_addr, offset, 1'b0, 1'b1, 6'b0, 1'b1, 4'b0, btt};
  endfunction

endpackage

// File: rtl/event_store_tracker.sv
// In-flight command tracker: FIFO of {overflow, short, tag, upper_addr}; the
// header is pushed at command issue and the length flags are filled in later.
module event_store_tracker
  import event_store_pkg::*;
#(
  parameter int DEPTH = TRACK_DEPTH_DEF
) (
  input  logic                     memclk,
  input  logic                     memresetn,
  input  logic                     push,
  input  logic [15:0]              push_hdr,
  input  logic                     flag_we,
  input  logic [1:0]               flag_data,
  input  logic                     pop,
  output logic [17:0]              head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr_reg;
  logic [AW:0]   rd_ptr_reg;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] last_idx;
  logic          push_ok;
  logic          pop_ok;
  logic [17:0]   entry [DEPTH];

  assign wr_idx   = wr_ptr_reg[AW-1:0];
  assign rd_idx   = rd_ptr_reg[AW-1:0];
  assign last_idx = wr_idx - 1'b1;
  assign count    = wr_ptr_reg - rd_ptr_reg;
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign head     = entry[rd_idx];

  always_ff @(posedge memclk or negedge memresetn) begin
    if (!memresetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [15:0] hdr_reg;
      logic [1:0]  flag_reg;

      // Flags always target the most recently pushed entry
      always_ff @(posedge memclk or negedge memresetn) begin
        if (!memresetn) begin
          hdr_reg  <= '0;
          flag_reg <= '0;
        end else if (push_ok && wr_idx == AW'(gi)) begin
          hdr_reg  <= push_hdr;
          flag_reg <= '0;
        end else if (flag_we && last_idx == AW'(gi)) begin
          flag_reg <= flag_data;
        end
      end

      assign entry[gi] = {flag_reg, hdr_reg};
    end
  endgenerate

endmodule

// File: rtl/event_store_generator.sv
// Pairs event streams with free buffers, issues S2MM commands, enforces the
// event length and turns S2MM status into 24-bit header completions.
module event_store_generator
  import event_store_pkg::*;
#(
  parameter logic [18:0] START_OFFSET = START_OFFSET_DEF,
  parameter logic [18:0] EVENT_BYTES  = EVENT_BYTES_DEF,
  parameter int          TRACK_DEPTH  = TRACK_DEPTH_DEF
) (
  input  logic        memclk,
  input  logic        memresetn,
  input  logic [11:0] s_addr_tdata,
  input  logic        s_addr_tvalid,
  output logic        s_addr_tready,
  input  logic [63:0] s_ev_tdata,
  input  logic        s_ev_tvalid,
  input  logic        s_ev_tlast,
  output logic        s_ev_tready,
  output logic [71:0] m_cmd_tdata,
  output logic        m_cmd_tvalid,
  input  logic        m_cmd_tready,
  output logic [63:0] m_wr_tdata,
  output logic        m_wr_tvalid,
  output logic        m_wr_tlast,
  output logic [7:0]  m_wr_tkeep,
  input  logic        m_wr_tready,
  input  logic [7:0]  s_sts_tdata,
  input  logic        s_sts_tvalid,
  output logic        s_sts_tready,
  output logic [23:0] m_cmpl_tdata,
  output logic        m_cmpl_tvalid,
  input  logic        m_cmpl_tready,
  output logic [2:0]  inflight_o,
  output logic        any_err_o
);

  localparam logic [15:0] QW_LAST = qwords_of(EVENT_BYTES) - 16'd1;
  localparam int          CW      = $clog2(TRACK_DEPTH) + 1;

  state_t      state_reg, state_next;
  logic [3:0]  tag_reg;
  logic [11:0] addr_reg;
  logic [15:0] cnt_reg;
  logic        run_reg;
  logic        beat_acc;
  logic        last_beat;

  logic          trk_push;
  logic          trk_flag_we;
  logic [1:0]    trk_flag_data;
  logic          trk_pop;
  logic [17:0]   trk_head;
  logic          trk_full;
  logic          trk_empty;
  logic [CW-1:0] trk_count;
  logic          trk_ovf, trk_short;
  logic [3:0]    trk_tag;
  logic [11:0]   trk_addr;

  logic        cmpl_valid_reg;
  logic [23:0] cmpl_data_reg;
  logic        any_err_reg;
  logic        sts_acc;
  logic [7:0]  err;

  assign m_cmd_tdata = make_cmd(tag_reg, addr_reg, START_OFFSET, EVENT_BYTES);
  assign m_wr_tdata  = s_ev_tdata;
  assign m_wr_tkeep  = 8'hFF;
  assign last_beat   = (cnt_reg == QW_LAST);

  always_ff @(posedge memclk or negedge memresetn) begin
    if (!memresetn) state_reg <= IDLE;
    else            state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    s_addr_tready = 1'b0;
    m_cmd_tvalid  = 1'b0;
    s_ev_tready   = 1'b0;
    m_wr_tvalid   = 1'b0;
    m_wr_tlast    = 1'b0;
    trk_push      = 1'b0;
    trk_flag_we   = 1'b0;
    trk_flag_data = 2'b00;
    beat_acc      = 1'b0;
    case (state_reg)
      IDLE: begin
        // run_reg keeps s_addr_tready low while reset is held
        if (run_reg && s_addr_tvalid && s_ev_tvalid && !trk_full) begin
          s_addr_tready = 1'b1;
          state_next    = ISSUE_CMD;
        end
      end
      ISSUE_CMD: begin
        m_cmd_tvalid = 1'b1;
        if (m_cmd_tready) begin
          trk_push   = 1'b1;
          state_next = STREAM;
        end
      end
      STREAM: begin
        m_wr_tvalid = s_ev_tvalid;
        s_ev_tready = m_wr_tready;
        m_wr_tlast  = last_beat || s_ev_tlast;
        if (s_ev_tvalid && m_wr_tready) begin
          beat_acc = 1'b1;
          if (m_wr_tlast) begin
            trk_flag_we   = 1'b1;
            trk_flag_data = {last_beat && !s_ev_tlast, s_ev_tlast && !last_beat};
            state_next    = (last_beat && !s_ev_tlast) ? DRAIN : IDLE;
          end
        end
      end
      DRAIN: begin
        s_ev_tready = 1'b1;
        if (s_ev_tvalid && s_ev_tlast) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge memclk or negedge memresetn) begin
    if (!memresetn) begin
      tag_reg  <= '0;
      addr_reg <= '0;
      cnt_reg  <= '0;
      run_reg  <= 1'b0;
    end else begin
      run_reg <= 1'b1;
      if (s_addr_tready) addr_reg <= s_addr_tdata;
      if (trk_push) begin
        tag_reg <= tag_reg + 4'd1;
        cnt_reg <= '0;
      end else if (beat_acc) begin
        cnt_reg <= cnt_reg + 16'd1;
      end
    end
  end

  event_store_tracker #(.DEPTH(TRACK_DEPTH)) u_tracker (
    .memclk    (memclk),
    .memresetn (memresetn),
    .push      (trk_push),
    .push_hdr  ({tag_reg, addr_reg}),
    .flag_we   (trk_flag_we),
    .flag_data (trk_flag_data),
    .pop       (trk_pop),
    .head      (trk_head),
    .full      (trk_full),
    .empty     (trk_empty),
    .count     (trk_count)
  );

  assign {trk_ovf, trk_short, trk_tag, trk_addr} = trk_head;

  // Status path runs independently of the command FSM
  assign s_sts_tready = !trk_empty && (!cmpl_valid_reg || m_cmpl_tready);
  assign sts_acc      = s_sts_tready && s_sts_tvalid;
  assign trk_pop      = sts_acc;

  always_comb begin
    err               = 8'h00;
    err[ERR_NOT_OK]   = !s_sts_tdata[STS_OK];
    err[ERR_RESP]     = s_sts_tdata[STS_SLVERR] | s_sts_tdata[STS_DECERR];
    err[ERR_INTERR]   = s_sts_tdata[STS_INTERR];
    err[ERR_SHORT]    = trk_short;
    err[ERR_OVERFLOW] = trk_ovf;
    err[ERR_TAG]      = (s_sts_tdata[3:0] != trk_tag);
  end

  always_ff @(posedge memclk or negedge memresetn) begin
    if (!memresetn) begin
      cmpl_valid_reg <= 1'b0;
      cmpl_data_reg  <= '0;
      any_err_reg    <= 1'b0;
    end else if (sts_acc) begin
      cmpl_valid_reg <= 1'b1;
      cmpl_data_reg  <= {trk_tag, trk_addr, err};
      if (err != 8'h00) any_err_reg <= 1'b1;
    end else if (m_cmpl_tready) begin
      cmpl_valid_reg <= 1'b0;
    end
  end

  assign m_cmpl_tvalid = cmpl_valid_reg;
  assign m_cmpl_tdata  = cmpl_data_reg;
  assign any_err_o     = any_err_reg;
  assign inflight_o    = 3'(trk_count);

endmodule

// File: tb/tb_event_store_generator.sv
// Directed bench for event_store_generator with a shortened event (1024 bytes,
// 128 qwords) so every scenario fits a short run.
module tb_event_store_generator;

  localparam logic [18:0] TB_BYTES = 19'd1024;
  localparam int          QW       = 128;

  logic        memclk = 1'b0;
  logic        memresetn = 1'b0;
  logic [11:0] s_addr_tdata = '0;
  logic        s_addr_tvalid = 1'b0;
  logic        s_addr_tready;
  logic [63:0] s_ev_tdata = '0;
  logic        s_ev_tvalid = 1'b0;
  logic        s_ev_tlast = 1'b0;
  logic        s_ev_tready;
  logic [71:0] m_cmd_tdata;
  logic        m_cmd_tvalid;
  logic        m_cmd_tready = 1'b1;
  logic [63:0] m_wr_tdata;
  logic        m_wr_tvalid;
  logic        m_wr_tlast;
  logic [7:0]  m_wr_tkeep;
  logic        m_wr_tready = 1'b1;
  logic [7:0]  s_sts_tdata = '0;
  logic        s_sts_tvalid = 1'b0;
  logic        s_sts_tready;
  logic [23:0] m_cmpl_tdata;
  logic        m_cmpl_tvalid;
  logic        m_cmpl_tready = 1'b1;
  logic [2:0]  inflight_o;
  logic        any_err_o;

  int          checks = 0;
  int          failures = 0;
  logic [71:0] last_cmd = '0;
  int          cmd_seen = 0;

  always #5 memclk = ~memclk;

  event_store_generator #(
    .START_OFFSET (19'h03E00),
    .EVENT_BYTES  (TB_BYTES),
    .TRACK_DEPTH  (4)
  ) dut (
    .memclk        (memclk),
    .memresetn     (memresetn),
    .s_addr_tdata  (s_addr_tdata),
    .s_addr_tvalid (s_addr_tvalid),
    .s_addr_tready (s_addr_tready),
    .s_ev_tdata    (s_ev_tdata),
    .s_ev_tvalid   (s_ev_tvalid),
    .s_ev_tlast    (s_ev_tlast),
    .s_ev_tready   (s_ev_tready),
    .m_cmd_tdata   (m_cmd_tdata),
    .m_cmd_tvalid  (m_cmd_tvalid),
    .m_cmd_tready  (m_cmd_tready),
    .m_wr_tdata    (m_wr_tdata),
    .m_wr_tvalid   (m_wr_tvalid),
    .m_wr_tlast    (m_wr_tlast),
    .m_wr_tkeep    (m_wr_tkeep),
    .m_wr_tready   (m_wr_tready),
    .s_sts_tdata   (s_sts_tdata),
    .s_sts_tvalid  (s_sts_tvalid),
    .s_sts_tready  (s_sts_tready),
    .m_cmpl_tdata  (m_cmpl_tdata),
    .m_cmpl_tvalid (m_cmpl_tvalid),
    .m_cmpl_tready (m_cmpl_tready),
    .inflight_o    (inflight_o),
    .any_err_o     (any_err_o)
  );

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] beat_word(input logic [11:0] addr, input int b);
    return {addr, 20'h5A5A5, b};
  endfunction

  task automatic do_reset();
    s_addr_tvalid = 1'b0;
    s_ev_tvalid   = 1'b0;
    s_ev_tlast    = 1'b0;
    s_sts_tvalid  = 1'b0;
    memresetn     = 1'b0;
    repeat (3) @(negedge memclk);
    memresetn = 1'b1;
    repeat (2) @(negedge memclk);
  endtask

  // Offers one buffer address plus nbeats qwords; input tlast on beat tlast_at.
  // Returns the first beat index carrying m_wr_tlast, forwarded and dropped counts.
  task automatic send_event(input logic [11:0] addr, input int nbeats, input int tlast_at,
                            output int wr_last, output int fwd, output int drop);
    int   b = 0;
    int   guard = 0;
    int   bad = 0;
    logic addr_pop;
    logic acc;
    wr_last = -1;
    fwd     = 0;
    drop    = 0;
    @(negedge memclk);
    s_addr_tdata  = addr;
    s_addr_tvalid = 1'b1;
    s_ev_tdata    = beat_word(addr, 0);
    s_ev_tlast    = (tlast_at == 0);
    s_ev_tvalid   = 1'b1;
    while (b < nbeats && guard < 4000) begin
      #1;
      addr_pop = s_addr_tvalid && s_addr_tready;
      acc      = s_ev_tvalid && s_ev_tready;
      if (m_cmd_tvalid && m_cmd_tready) begin
        last_cmd = m_cmd_tdata;
        cmd_seen++;
      end
      if (acc) begin
        if (m_wr_tvalid) begin
          fwd++;
          if (m_wr_tdata !== s_ev_tdata || m_wr_tkeep !== 8'hFF) bad++;
          if (m_wr_tlast && wr_last < 0) wr_last = b;
        end else begin
          drop++;
        end
        b++;
      end
      @(negedge memclk);
      guard++;
      if (addr_pop) s_addr_tvalid = 1'b0;
      if (acc) begin
        if (b < nbeats) begin
          s_ev_tdata = beat_word(addr, b);
          s_ev_tlast = (b == tlast_at);
        end else begin
          s_ev_tvalid = 1'b0;
          s_ev_tlast  = 1'b0;
        end
      end
    end
    check("stream_done_in_budget", (guard < 4000), 1);
    check("stream_data_keep", bad, 0);
    $display("event addr=%h beats=%0d wr_last=%0d fwd=%0d drop=%0d", addr, nbeats, wr_last, fwd, drop);
  endtask

  task automatic send_sts(input string tag, input logic [7:0] sts, input logic [23:0] exp);
    int g = 0;
    s_sts_tdata  = sts;
    s_sts_tvalid = 1'b1;
    #1;
    while (!s_sts_tready && g < 50) begin
      @(negedge memclk);
      #1;
      g++;
    end
    check({tag, "_sts_accept"}, (g < 50), 1);
    @(negedge memclk);
    s_sts_tvalid = 1'b0;
    #1;
    check({tag, "_valid"}, m_cmpl_tvalid, 1);
    check(tag, m_cmpl_tdata, exp);
    $display("status %h -> cmpl %h", sts, m_cmpl_tdata);
  endtask

  initial begin
    int          wl, fw, dr;
    int          cnt;
    logic [71:0] exp_cmd;

    // Reset state, with upstream valids high to prove nothing is accepted
    s_addr_tvalid = 1'b1;
    s_ev_tvalid   = 1'b1;
    repeat (3) @(negedge memclk);
    #1;
    check("rst_addr_tready", s_addr_tready, 0);
    check("rst_ev_tready", s_ev_tready, 0);
    check("rst_cmd_tvalid", m_cmd_tvalid, 0);
    check("rst_wr_tvalid", m_wr_tvalid, 0);
    check("rst_sts_tready", s_sts_tready, 0);
    check("rst_cmpl_tvalid", m_cmpl_tvalid, 0);
    check("rst_inflight", inflight_o, 0);
    check("rst_any_err", any_err_o, 0);
    do_reset();

    // 1: clean event
    send_event(12'h123, QW, QW - 1, wl, fw, dr);
    exp_cmd = {4'h0, 4'h0, 1'b0, 12'h123, 19'h03E00, 1'b0, 1'b1, 6'b0, 1'b1, 4'b0, 19'd1024};
    check("t1_cmd_seen", cmd_seen, 1);
    check("t1_cmd", last_cmd, exp_cmd);
    check("t1_wr_last", wl, QW - 1);
    check("t1_fwd", fw, QW);
    check("t1_inflight", inflight_o, 1);
    send_sts("t1_cmpl", 8'h80, 24'h012300);

    // 2: short event, tlast on beat 100
    send_event(12'h456, 101, 100, wl, fw, dr);
    #1;
    check("t2_back_idle", s_ev_tready, 0);
    check("t2_wr_last", wl, 100);
    check("t2_fwd", fw, 101);
    send_sts("t2_cmpl", 8'h81, 24'h145608);

    // 3: overlong event, forced tlast then drain
    send_event(12'h789, QW + 40, QW + 39, wl, fw, dr);
    check("t3_wr_last", wl, QW - 1);
    check("t3_fwd", fw, QW);
    check("t3_drop", dr, 40);
    send_sts("t3_cmpl", 8'h82, 24'h278910);

    // 4: fill the tracker, fifth event must wait
    do_reset();
    for (int i = 0; i < 4; i++) send_event(12'hA00 + 12'(i), QW, QW - 1, wl, fw, dr);
    check("t4_inflight_full", inflight_o, 4);
    s_addr_tdata  = 12'hA04;
    s_addr_tvalid = 1'b1;
    s_ev_tdata    = '0;
    s_ev_tvalid   = 1'b1;
    cnt = 0;
    repeat (6) begin
      #1;
      if (s_addr_tready || m_cmd_tvalid) cnt++;
      @(negedge memclk);
    end
    check("t4_full_blocks", cnt, 0);
    s_addr_tvalid = 1'b0;
    s_ev_tvalid   = 1'b0;
    send_sts("t4_cmpl0", 8'h80, 24'h0A0000);
    send_sts("t4_cmpl1", 8'h81, 24'h1A0100);
    send_sts("t4_cmpl2", 8'h82, 24'h2A0200);
    send_sts("t4_cmpl3", 8'h83, 24'h3A0300);
    check("t4_inflight_empty", inflight_o, 0);
    check("t4_no_err", any_err_o, 0);

    // 5: SLVERR, completion held under backpressure
    send_event(12'hB00, QW, QW - 1, wl, fw, dr);
    send_event(12'hB01, QW, QW - 1, wl, fw, dr);
    m_cmpl_tready = 1'b0;
    send_sts("t5_cmpl_slverr", 8'h44, 24'h4B0003);
    s_sts_tdata  = 8'h85;
    s_sts_tvalid = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge memclk);
      #1;
      if (!m_cmpl_tvalid || m_cmpl_tdata !== 24'h4B0003 || s_sts_tready) cnt++;
    end
    check("t5_hold_stable", cnt, 0);
    check("t5_any_err", any_err_o, 1);
    m_cmpl_tready = 1'b1;
    send_sts("t5_cmpl_next", 8'h85, 24'h5B0100);
    @(negedge memclk);
    #1;
    check("t5_cmpl_drained", m_cmpl_tvalid, 0);
    check("t5_any_err_sticky", any_err_o, 1);

    // 6: reset in the middle of a stream
    @(negedge memclk);
    s_addr_tdata  = 12'hC00;
    s_addr_tvalid = 1'b1;
    s_ev_tdata    = 64'h1;
    s_ev_tlast    = 1'b0;
    s_ev_tvalid   = 1'b1;
    repeat (20) @(negedge memclk);
    #1;
    check("t6_pre_inflight", inflight_o, 1);
    check("t6_pre_wr_tvalid", m_wr_tvalid, 1);
    #2;
    memresetn = 1'b0;
    #1;
    check("t6_rst_wr_tvalid", m_wr_tvalid, 0);
    check("t6_rst_ev_tready", s_ev_tready, 0);
    check("t6_rst_addr_tready", s_addr_tready, 0);
    check("t6_rst_inflight", inflight_o, 0);
    check("t6_rst_any_err", any_err_o, 0);
    do_reset();
    send_event(12'hD00, QW, QW - 1, wl, fw, dr);
    check("t6_tag_restart", last_cmd[71:68], 4'h0);
    check("t6_fwd", fw, QW);
    send_sts("t6_cmpl", 8'h80, 24'h0D0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
